// File: rtl/crc7_encoder.sv
// Bit-serial CRC-7 encoder: latches a 16-bit word, runs it MSB first through a
// 7-bit LFSR and presents {data, crc} with a one-cycle done pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for en_data; DATA_OUT holds the last codeword
// SHIFT | one data bit per clock into the LFSR, 16 cycles per word
module crc7_encoder #(
   parameter logic [6:0] POLY     = 7'h09,
   parameter logic [6:0] CRC_INIT = 7'h00
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        en_data,
   input  logic [15:0] DATA_IN,
   output logic [22:0] DATA_OUT,
   output logic        busy,
   output logic        done
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] sr_q, sr_d;
   logic [15:0] dh_q, dh_d;
   logic [6:0]  crc_q, crc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [22:0] data_out_q, data_out_d;
   logic        done_q, done_d;
   logic        fb;
   logic [6:0]  crc_step;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         dh_q       <= '0;
         crc_q      <= '0;
         cnt_q      <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         dh_q       <= dh_d;
         crc_q      <= crc_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end

   // LFSR step for the current data bit; also feeds the completion capture
   assign fb       = sr_q[15] ^ crc_q[6];
   assign crc_step = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'h00);

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      dh_d       = dh_q;
      crc_d      = crc_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_data) begin
               sr_d    = DATA_IN;
               dh_d    = DATA_IN;
               crc_d   = CRC_INIT;
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            crc_d = crc_step;
            sr_d  = {sr_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               data_out_d = {dh_q, crc_step};
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign DATA_OUT = data_out_q;
   assign busy     = (state_q == SHIFT);
   assign done     = done_q;

endmodule

// File: tb/tb_crc7_encoder.sv
// Scoreboard bench for crc7_encoder: expected codewords come from polynomial
// long division and are matched against each done pulse by a monitor.
module tb_crc7_encoder;

   localparam logic [6:0] POLY = 7'h09;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_data = 1'b0;
   logic [15:0] DATA_IN = '0;
   logic [22:0] DATA_OUT;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [22:0] exp_q[$];

   crc7_encoder #(.POLY(POLY), .CRC_INIT(7'h00)) dut (
      .CLK(CLK), .reset(rst_n), .en_data(en_data), .DATA_IN(DATA_IN),
      .DATA_OUT(DATA_OUT), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Remainder of v (degree <= 22) modulo x^7 + POLY
   function automatic logic [6:0] rem23(input logic [22:0] v);
      logic [22:0] r;
      logic [22:0] g;
      r = v;
      g = {15'h0, 1'b1, POLY};
      for (int i = 22; i >= 7; i--)
         if (r[i]) r = r ^ (g << (i - 7));
      return r[6:0];
   endfunction

   function automatic logic [22:0] codeword(input logic [15:0] d);
      return {d, rem23({d, 7'h00})};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the head of the scoreboard queue
   always @(negedge CLK) begin
      if (rst_n && done) begin
         logic [22:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: DATA_OUT=%0h with no word pending", DATA_OUT);
         end else begin
            e = exp_q.pop_front();
            if (DATA_OUT !== e) begin
               errors++;
               $display("FAIL codeword: got %0h, expected %0h", DATA_OUT, e);
            end
         end
         checks++;
         if (rem23(DATA_OUT) != 7'h00) begin
            errors++;
            $display("FAIL syndrome: codeword %0h leaves remainder %0h", DATA_OUT, rem23(DATA_OUT));
         end
         checks++;
         if (busy) begin
            errors++;
            $display("FAIL done_busy: busy=%0b during done, expected 0", busy);
         end
      end
   end

   task automatic issue(input logic [15:0] d, input bit push, input logic [22:0] e);
      @(negedge CLK);
      en_data = 1'b1;
      DATA_IN = d;
      if (push) exp_q.push_back(e);
      @(negedge CLK);
      en_data = 1'b0;
   endtask

   task automatic wait_done(output int at);
      int n;
      n = 0;
      at = -1;
      while (n < 40) begin
         @(negedge CLK);
         n++;
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: no done within 40 cycles, expected one");
      end
   endtask

   initial begin
      int t1, t2, t3;
      logic [15:0] d;
      repeat (3) @(negedge CLK);
      check("reset_data_out", 32'(DATA_OUT), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      rst_n = 1'b1;

      issue(16'h0000, 1'b1, 23'h000000);
      check("busy_after_accept", 32'(busy), 32'h1);
      wait_done(t1);
      issue(16'h0001, 1'b1, 23'h000089);
      wait_done(t1);
      issue(16'h8000, 1'b1, 23'h400053);
      wait_done(t1);

      // back-to-back: re-strobe in the done cycle
      issue(16'h8001, 1'b1, 23'h4000DA);
      wait_done(t1);
      en_data = 1'b1;
      DATA_IN = 16'h0001;
      exp_q.push_back(23'h000089);
      @(negedge CLK);
      en_data = 1'b0;
      check("b2b_busy", 32'(busy), 32'h1);
      wait_done(t2);
      check("b2b_spacing", 32'(t2 - t1), 32'd17);

      // en_data while busy is ignored; DATA_OUT holds the previous codeword
      issue(16'h8000, 1'b1, 23'h400053);
      repeat (3) @(negedge CLK);
      en_data = 1'b1;
      DATA_IN = 16'hFFFF;
      @(negedge CLK);
      en_data = 1'b0;
      check("ignore_busy", 32'(busy), 32'h1);
      check("hold_data_out", 32'(DATA_OUT), 32'h000089);
      wait_done(t1);
      repeat (20) @(negedge CLK);

      // reset mid-SHIFT discards the word
      issue(16'h8000, 1'b0, 23'h0);
      repeat (6) @(negedge CLK);
      rst_n = 1'b0;
      #1;
      check("midrst_data_out", 32'(DATA_OUT), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
      repeat (20) @(negedge CLK);
      issue(16'h0001, 1'b1, 23'h000089);
      wait_done(t1);

      // en_data held high: a new word every 17 cycles
      @(negedge CLK);
      en_data = 1'b1;
      DATA_IN = 16'hA5C3;
      for (int k = 0; k < 3; k++) exp_q.push_back(codeword(16'hA5C3));
      wait_done(t1);
      wait_done(t2);
      wait_done(t3);
      en_data = 1'b0;
      check("held_spacing1", 32'(t2 - t1), 32'd17);
      check("held_spacing2", 32'(t3 - t2), 32'd17);

      for (int k = 0; k < 200; k++) begin
         d = 16'($urandom);
         issue(d, 1'b1, codeword(d));
         wait_done(t1);
      end

      repeat (20) @(negedge CLK);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
